// File: rtl/gate_id_pkg.sv
// Shared types and helpers for the two-input gate identifier.
// Holds the classification code enum, reference truth tables and the classifier function.
package gate_id_pkg;

    typedef enum logic [3:0] {
        GID_NONE     = 4'd0,
        GID_AND      = 4'd1,
        GID_OR       = 4'd2,
        GID_NAND     = 4'd3,
        GID_NOR      = 4'd4,
        GID_XOR      = 4'd5,
        GID_XNOR     = 4'd6,
        GID_NOT_A    = 4'd7,
        GID_OTHER    = 4'd8,
        GID_CONFLICT = 4'd9,
        GID_TIMEOUT  = 4'd10
    } gate_id_e;

    // Table bit index is {a,b}: bit3 = ab 11, bit0 = ab 00
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;
    localparam logic [3:0] TT_NOT_A = 4'b0011;

    function automatic gate_id_e classify(input logic [3:0] table_bits);
        gate_id_e id;
        case (table_bits)
            TT_AND:   id = GID_AND;
            TT_OR:    id = GID_OR;
            TT_NAND:  id = GID_NAND;
            TT_NOR:   id = GID_NOR;
            TT_XOR:   id = GID_XOR;
            TT_XNOR:  id = GID_XNOR;
            TT_NOT_A: id = GID_NOT_A;
            default:  id = GID_OTHER;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/gate_identifier_classify.sv
// Combinational truth-table classifier; maps a complete 4-entry table to a gate code.
module gate_identifier_classify
    import gate_id_pkg::*;
(
    input  logic [3:0] truth_table,
    output gate_id_e   gate_id
);

    assign gate_id = classify(truth_table);

endmodule

// File: rtl/gate_identifier.sv
// Observer that captures (a,b,y) samples into a truth table and identifies the gate.
// Reports a classification, a conflict, or a timeout with a one-cycle done pulse.
module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       sample_a,
    input  logic       sample_b,
    input  logic       sample_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic [3:0] truth_table,
    output logic [3:0] seen_mask
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    gate_id_e         result_q;
    logic [3:0]       table_q;
    logic [3:0]       mask_q;

    logic [1:0] idx;
    logic       accept;
    logic       conflict;
    logic       complete;
    logic       timed_out;
    logic [3:0] next_table;
    logic [3:0] next_mask;
    gate_id_e   next_id;

    assign sample_ready = (state == ST_COLLECT);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_REPORT);
    assign result       = result_q;
    assign truth_table  = table_q;
    assign seen_mask    = mask_q;

    assign idx    = {sample_a, sample_b};
    assign accept = sample_valid && sample_ready;

    always_comb begin
        next_table = table_q;
        next_mask  = mask_q;
        conflict   = 1'b0;
        if (accept) begin
            if (mask_q[idx]) begin
                conflict = (table_q[idx] != sample_y);
            end else begin
                next_table[idx] = sample_y;
                next_mask[idx]  = 1'b1;
            end
        end
    end

    // Completion and timeout both look at this cycle's updated mask
    assign complete  = (next_mask == 4'b1111);
    assign timed_out = (count == CNT_LAST);

    gate_identifier_classify u_classify (
        .truth_table (next_table),
        .gate_id     (next_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            result_q <= GID_NONE;
            table_q  <= '0;
            mask_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        result_q <= GID_NONE;
                        table_q  <= '0;
                        mask_q   <= '0;
                        state    <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    count <= count + 1'b1;
                    if (conflict) begin
                        result_q <= GID_CONFLICT;
                        state    <= ST_REPORT;
                    end else begin
                        table_q <= next_table;
                        mask_q  <= next_mask;
                        if (complete) begin
                            result_q <= next_id;
                            state    <= ST_REPORT;
                        end else if (timed_out) begin
                            result_q <= GID_TIMEOUT;
                            state    <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: scoreboard of expected reports checked on each done pulse.
module tb_gate_identifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start_to;
    logic       sample_valid, sample_a, sample_b, sample_y;
    logic       sample_ready, busy, done;
    logic [3:0] result, truth_table, seen_mask;
    logic       ready_to, busy_to, done_to;
    logic [3:0] result_to, tt_to, seen_to;

    typedef struct {
        logic [3:0] res;
        logic [3:0] tt;
        logic [3:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   done_cyc  = -1;

    always #5 clk = ~clk;

    gate_identifier dut (
        .clk (clk), .rst (rst), .start (start),
        .sample_valid (sample_valid), .sample_ready (sample_ready),
        .sample_a (sample_a), .sample_b (sample_b), .sample_y (sample_y),
        .busy (busy), .done (done), .result (result),
        .truth_table (truth_table), .seen_mask (seen_mask)
    );

    gate_identifier #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk (clk), .rst (rst), .start (start_to),
        .sample_valid (sample_valid), .sample_ready (ready_to),
        .sample_a (sample_a), .sample_b (sample_b), .sample_y (sample_y),
        .busy (busy_to), .done (done_to), .result (result_to),
        .truth_table (tt_to), .seen_mask (seen_to)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_result", {28'd0, result}, {28'd0, e.res});
                check("sb_table", {28'd0, truth_table}, {28'd0, e.tt});
                check("sb_mask", {28'd0, seen_mask}, {28'd0, e.mask});
            end
        end
    endtask

    task automatic send(input logic a, input logic b, input logic y);
        sample_valid = 1'b1;
        sample_a = a;
        sample_b = b;
        sample_y = y;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] res, input logic [3:0] tt, input logic [3:0] mask);
        exp_t e;
        e.res = res;
        e.tt = tt;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (done_cyc == cyc) got = 1'b1;
        end
        check(tag, {31'd0, got}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_to = 1'b0;
        sample_valid = 1'b0;
        sample_a = 1'b0;
        sample_b = 1'b0;
        sample_y = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, sample_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_table", {28'd0, truth_table}, 32'd0);
        check("rst_mask", {28'd0, seen_mask}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // AND, back-to-back samples: done in the cycle after the 4th accept
        kick();
        check("and_busy", {31'd0, busy}, 32'd1);
        check("and_ready", {31'd0, sample_ready}, 32'd1);
        push(4'd1, 4'b1000, 4'b1111);
        send(0, 0, 0);
        send(0, 1, 0);
        send(1, 0, 0);
        check("and_no_early_done", {31'd0, done}, 32'd0);
        send(1, 1, 1);
        check("and_latency", done_cyc, cyc);
        check("and_report_ready", {31'd0, sample_ready}, 32'd0);
        step();
        check("and_idle_busy", {31'd0, busy}, 32'd0);
        check("and_hold_result", {28'd0, result}, 32'd1);

        // XNOR with gaps and a duplicate entry
        kick();
        push(4'd6, 4'b1001, 4'b1111);
        send(1, 1, 1);
        step();
        send(0, 0, 1);
        check("xnor_live_mask", {28'd0, seen_mask}, 32'b1001);
        step();
        send(0, 0, 1);
        check("xnor_dup_mask", {28'd0, seen_mask}, 32'b1001);
        send(0, 1, 0);
        step();
        send(1, 0, 0);
        check("xnor_done", done_cyc, cyc);
        step();

        // Conflict on a repeated index with a different y
        kick();
        push(4'd9, 4'b0010, 4'b0011);
        send(0, 0, 0);
        send(0, 1, 1);
        send(0, 0, 1);
        check("conflict_latency", done_cyc, cyc);
        step();

        // Timeout with 3 of 4 entries after 8 COLLECT cycles
        start_to = 1'b1;
        step();
        start_to = 1'b0;
        send(0, 0, 0);
        send(0, 1, 1);
        send(1, 0, 1);
        for (int i = 0; i < 4; i++) step();
        check("to_not_yet", {31'd0, done_to}, 32'd0);
        step();
        check("to_done", {31'd0, done_to}, 32'd1);
        check("to_result", {28'd0, result_to}, 32'd10);
        check("to_mask", {28'd0, seen_to}, 32'b0111);
        check("to_table", {28'd0, tt_to}, 32'b0110);
        step();

        // Completing sample on the final timeout cycle classifies instead
        start_to = 1'b1;
        step();
        start_to = 1'b0;
        send(0, 0, 0);
        send(0, 1, 1);
        send(1, 0, 1);
        for (int i = 0; i < 4; i++) step();
        send(1, 1, 0);
        check("edge_done", {31'd0, done_to}, 32'd1);
        check("edge_result", {28'd0, result_to}, 32'd5);
        step();

        // NOT_A with start held through COLLECT and REPORT
        kick();
        start = 1'b1;
        push(4'd7, 4'b0011, 4'b1111);
        send(0, 0, 1);
        send(0, 1, 1);
        send(1, 0, 0);
        send(1, 1, 0);
        check("nota_done", done_cyc, cyc);
        step();
        start = 1'b0;
        step();
        check("nota_start_ignored", {31'd0, busy}, 32'd0);
        check("nota_hold_table", {28'd0, truth_table}, 32'b0011);

        // OTHER
        kick();
        push(4'd8, 4'b0100, 4'b1111);
        send(0, 0, 0);
        send(0, 1, 0);
        send(1, 0, 1);
        send(1, 1, 0);
        check("other_done", done_cyc, cyc);
        step();

        // Asynchronous reset mid-COLLECT, then a fresh NOR run
        kick();
        send(0, 0, 1);
        send(0, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, sample_ready}, 32'd0);
        check("mid_rst_mask", {28'd0, seen_mask}, 32'd0);
        check("mid_rst_table", {28'd0, truth_table}, 32'd0);
        check("mid_rst_result", {28'd0, result}, 32'd0);
        step();
        check("mid_rst_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();
        kick();
        push(4'd4, 4'b0001, 4'b1111);
        send(0, 0, 1);
        send(1, 1, 0);
        step();
        send(1, 0, 0);
        sample_valid = 1'b1;
        sample_a = 1'b0;
        sample_b = 1'b1;
        sample_y = 1'b0;
        wait_done("nor_done", 4);
        sample_valid = 1'b0;
        step();

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
Name: gate_identifier

Overview:
- Inverse of a two-input gate evaluator: observes (a, b, y) samples from a device under observation and decides which logic function it implements.
- Captures a 4-entry truth table over a valid/ready sample stream.
- Classifies the table as AND, OR, NAND, NOR, XOR, XNOR, NOT_A or OTHER, and flags conflicting or missing data.
- Sits beside gate-level demo logic as a self-checking observer for benches and on-chip test.

Parameters:
- TIMEOUT_CYCLES, 64: maximum number of cycles spent in COLLECT before aborting with TIMEOUT; must be >= 4.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new identification; honoured only in IDLE
- sample_valid  in  1  sample_a/b/y are valid this cycle
- sample_ready  out  1  block accepts a sample this cycle
- sample_a  in  1  gate input a
- sample_b  in  1  gate input b
- sample_y  in  1  observed gate output
- busy  out  1  high in COLLECT and REPORT
- done  out  1  one-cycle pulse when result becomes valid
- result  out  4  gate_id_e classification code
- truth_table  out  4  captured table; bit index {a,b}
- seen_mask  out  4  which table entries have been captured

Behaviour:
- Reset (async, rst=1): state=IDLE; sample_ready, busy, done = 0; result=GID_NONE (0); truth_table=0; seen_mask=0; timeout counter=0.
- Reset asserted mid-operation aborts immediately with the same values. No done pulse.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - On start=1: clear truth_table, seen_mask and the counter; result=GID_NONE; go to COLLECT next cycle.
  - result and truth_table otherwise hold the last outcome.
- COLLECT:
  - sample_ready=1. A sample is accepted when sample_valid & sample_ready. Idx={sample_a,sample_b}.
  - Idx not yet seen: set truth_table[idx]=sample_y and seen_mask[idx]=1.
  - Idx already seen with the same y: no change.
  - Idx already seen with a different y: result=GID_CONFLICT; go to REPORT.
  - Counter increments every cycle in COLLECT. If the counter reaches TIMEOUT_CYCLES-1 with seen_mask != 4'b1111 after this cycle's update: result=GID_TIMEOUT; go to REPORT.
  - Priority within one cycle: conflict > completion > timeout. A sample accepted on the final timeout cycle that completes the table yields a classification, not TIMEOUT.
  - When seen_mask becomes 4'b1111 (updated value), classify on the same edge and go to REPORT.
- Classification (table bit3..bit0 = ab 11,10,01,00):
  - 1000 AND
  - 1110 OR
  - 0111 NAND
  - 0001 NOR
  - 0110 XOR
  - 1001 XNOR
  - 0011 NOT_A
  - anything else OTHER
- REPORT: lasts exactly one cycle. done=1, busy=1, sample_ready=0. Next state is IDLE.
- start is ignored outside IDLE, including in REPORT.
- Latency: done rises 1 cycle after the accepting edge of the completing or conflicting sample.
- Minimum time from start to done is 6 cycles with back-to-back valid samples.
- busy=0 in IDLE. truth_table and seen_mask are visible live during COLLECT.

Decomposition:
- Package gate_id_pkg:
  - typedef enum logic [3:0] gate_id_e: NONE=0, AND=1, OR=2, NAND=3, NOR=4, XOR=5, XNOR=6, NOT_A=7, OTHER=8, CONFLICT=9, TIMEOUT=10.
  - The seven 4-bit truth-table constants.
  - Function classify(table) returning gate_id_e.
- One combinational sub-module is natural: gate_id_classify (4-bit table in, gate_id_e out). Reusable by benches.
- The FSM, counter and capture registers stay in gate_identifier.

Test Plan:
- Feed AND samples (00→0, 01→0, 10→0, 11→1) back-to-back after start → done at cycle 6, result=AND(1), truth_table=1000.
- Feed XNOR samples in order 11,00,01,10, with duplicate 00→1 interleaved and gaps between valids → result=XNOR(6), truth_table=1001, duplicate ignored.
- Feed 00→0, 01→1, 00→1 → CONFLICT(9) done 1 cycle after third accept; seen_mask=0011.
- TIMEOUT_CYCLES=8, feed only ab=00,01,10 → done after cycle 8 of COLLECT, result=TIMEOUT(10), seen_mask=0111.
- Feed NOT_A table (0011) then OTHER table (0100) in two runs; assert start during COLLECT and REPORT → results 7 then 8; mid-run start ignored.
- Assert rst in the middle of COLLECT → all outputs 0 asynchronously, no done pulse; a fresh start then completes normally.
